// File: rtl/apb_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_master_bridge: valid/ready command stream to APB4 requester.      |
// | Optional macro APB_BRIDGE_TIMEOUT_EN adds an ACCESS-phase watchdog.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module apb_master_bridge #(
  parameter int NO_OF_SLAVES      = 13,
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_MEMORY_SIZE = 12,
  parameter int SLAVE_MEMORY_GAP  = 2,
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                      pclk_i,
  input  logic                      preset_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDRESS_WIDTH-1:0]  cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_strb_i,
  input  logic [2:0]                cmd_prot_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_slverr_o,
  output logic                      rsp_timeout_o,
  output logic [NO_OF_SLAVES-1:0]   pselx_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDRESS_WIDTH-1:0]  paddr_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic [DATA_WIDTH/8-1:0]   pstrb_o,
  output logic [2:0]                pprot_o,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  input  logic [DATA_WIDTH-1:0]     prdata_i
);

  if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 32 || DATA_WIDTH < 8 || DATA_WIDTH > 32) begin : g_bad_width
    $error("apb_master_bridge: ADDRESS_WIDTH/DATA_WIDTH out of range");
  end
  if (TIMEOUT_CYCLES < 1 || NO_OF_SLAVES < 1) begin : g_bad_count
    $error("apb_master_bridge: TIMEOUT_CYCLES and NO_OF_SLAVES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [63:0] REGION_BYTES = 64'(SLAVE_MEMORY_SIZE) * 64'd1024;
  localparam logic [63:0] STRIDE_BYTES = 64'(SLAVE_MEMORY_SIZE + SLAVE_MEMORY_GAP) * 64'd1024;

  logic [63:0]             addr_ext;
  logic [NO_OF_SLAVES-1:0] sel_d;

  assign addr_ext = 64'(cmd_addr_i);

  for (genvar i = 0; i < NO_OF_SLAVES; i++) begin : g_decode
    localparam logic [63:0] BASE = 64'(i) * STRIDE_BYTES;
    // Below BASE the subtraction wraps to a huge value, so one compare checks both bounds.
    assign sel_d[i] = (addr_ext - BASE) < REGION_BYTES;
  end

  state_t                    state_q;
  logic                      cmd_ready_q;
  logic                      rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q;
  logic                      rsp_slverr_q;
  logic [NO_OF_SLAVES-1:0]   pselx_q;
  logic                      penable_q;
  logic                      pwrite_q;
  logic [ADDRESS_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]     pwdata_q;
  logic [DATA_WIDTH/8-1:0]   pstrb_q;
  logic [2:0]                pprot_q;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] acc_cnt_q;
  logic             rsp_timeout_q;
  assign rsp_timeout_o = rsp_timeout_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      pselx_q       <= '0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      acc_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            if (|sel_d) begin
              pselx_q  <= sel_d;
              pwrite_q <= cmd_write_i;
              paddr_q  <= cmd_addr_i;
              pwdata_q <= cmd_write_i ? cmd_wdata_i : '0;
              pstrb_q  <= cmd_write_i ? cmd_strb_i : '0;
              pprot_q  <= cmd_prot_i;
              state_q  <= S_SETUP;
            end else begin
              // Unmapped address: answer locally, never touch the bus.
              rsp_valid_q  <= 1'b1;
              rsp_slverr_q <= 1'b1;
              rsp_rdata_q  <= '0;
              state_q      <= S_RESP;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        S_SETUP: begin
          penable_q <= 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
          acc_cnt_q <= '0;
`endif
          state_q   <= S_ACCESS;
        end

        S_ACCESS: begin
          if (pready_i) begin
            pselx_q      <= '0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_slverr_q <= pslverr_i;
            rsp_rdata_q  <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
            state_q      <= S_RESP;
          end
`ifdef APB_BRIDGE_TIMEOUT_EN
          else if (acc_cnt_q == CNT_LAST) begin
            pselx_q       <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= S_RESP;
          end else begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
`endif
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q   <= 1'b0;
            rsp_slverr_q  <= 1'b0;
            rsp_rdata_q   <= '0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
            cmd_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_slverr_o = rsp_slverr_q;
  assign pselx_o      = pselx_q;
  assign penable_o    = penable_q;
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign pstrb_o      = pstrb_q;
  assign pprot_o      = pprot_q;

endmodule
`default_nettype wire
